// File: rtl/morse_tap_timer_pkg.sv
// Shared types and constants for the Morse tap timer: FSM states, element
// values, letter sizing and default timing (also used by the decoder side).
package morse_tap_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } tap_state_e;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam int MAX_LEN = 5;
  localparam int LEN_W   = 3;
  localparam int CNT_W   = 12;

  localparam int DEF_TICK_DIV       = 100_000;
  localparam int DEF_DEBOUNCE_TICKS = 10;
  localparam int DEF_DOT_MAX_TICKS  = 200;
  localparam int DEF_LETTER_GAP     = 400;
  localparam int DEF_WORD_GAP       = 1000;

  // Complete control state of the timer; probes bind to this one register.
  typedef struct packed {
    tap_state_e         state;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] elems;
    logic [CNT_W-1:0]   dur;
    logic [CNT_W-1:0]   gap;
  } tap_ctl_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/morse_tap_timer_tick_debounce.sv
// Two-flop synchroniser followed by a tick-based stability filter: the output
// follows the input only after DEBOUNCE_TICKS consecutive ticks of disagreement.
module morse_tap_timer_tick_debounce
  import morse_tap_timer_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic cclk,
  input  logic rstb,
  input  logic tick,
  input  logic din,
  output logic dout
);

  localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    sync_q;
  logic [DW-1:0] stable_cnt;

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      sync_q     <= 2'b00;
      stable_cnt <= '0;
      dout       <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      // Any cycle of re-agreement restarts the count, so short bounces vanish.
      if (sync_q[1] == dout) begin
        stable_cnt <= '0;
      end else if (tick) begin
        if (stable_cnt == LAST) begin
          dout       <= sync_q[1];
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + DW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/morse_tap_timer.sv
// Turns a bouncy touch level into timed Morse events: per-element dot/dash,
// letter-complete after a letter gap, and a word boundary after a longer gap.
module morse_tap_timer
  import morse_tap_timer_pkg::*;
#(
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int DOT_MAX_TICKS  = DEF_DOT_MAX_TICKS,
  parameter int LETTER_GAP     = DEF_LETTER_GAP,
  parameter int WORD_GAP       = DEF_WORD_GAP
) (
  input  logic               cclk,
  input  logic               rstb,
  input  logic               key_raw,
  output logic               sym_valid,
  output logic               sym,
  output logic               letter_valid,
  output logic [MAX_LEN-1:0] letter_bits,
  output logic [LEN_W-1:0]   letter_len,
  output logic               word_gap,
  output logic               overflow,
  output logic               key_clean
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DOT_MAX_T = CNT_W'(DOT_MAX_TICKS);
  localparam logic [CNT_W-1:0] LETTER_T  = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WORD_T    = CNT_W'(WORD_GAP);
  localparam logic [LEN_W-1:0] MAX_LEN_T = LEN_W'(MAX_LEN);
  localparam tap_ctl_t CTL_RESET = '{state: ST_IDLE, len: '0, elems: '0, dur: '0, gap: '0};

  logic [PRE_W-1:0] pre_q;
  logic             tick;
  logic             key_q;
  logic             press;
  logic             release_e;
  logic [CNT_W-1:0] gap_inc;

  tap_ctl_t           ctl_q, ctl_d;
  logic               sym_valid_d, sym_d, letter_valid_d, word_gap_d, overflow_d;
  logic [MAX_LEN-1:0] letter_bits_d;
  logic [LEN_W-1:0]   letter_len_d;

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      pre_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PRE_W'(1);
    end
  end

  morse_tap_timer_tick_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_debounce (
    .cclk (cclk),
    .rstb (rstb),
    .tick (tick),
    .din  (key_raw),
    .dout (key_clean)
  );

  assign press     = key_clean & ~key_q;
  assign release_e = ~key_clean & key_q;
  assign gap_inc   = sat_inc(ctl_q.gap);

  always_comb begin
    ctl_d          = ctl_q;
    sym_valid_d    = 1'b0;
    sym_d          = sym;
    letter_valid_d = 1'b0;
    letter_bits_d  = letter_bits;
    letter_len_d   = letter_len;
    word_gap_d     = 1'b0;
    overflow_d     = 1'b0;
    unique case (ctl_q.state)
      ST_IDLE: begin
        if (press) begin
          ctl_d.state = ST_PRESS;
          ctl_d.dur   = '0;
        end
      end
      ST_PRESS: begin
        if (release_e) begin
          sym_valid_d = 1'b1;
          sym_d       = (ctl_q.dur > DOT_MAX_T) ? SYM_DASH : SYM_DOT;
          if (ctl_q.len < MAX_LEN_T) begin
            ctl_d.elems[ctl_q.len] = sym_d;
            ctl_d.len              = ctl_q.len + LEN_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
          ctl_d.state = ST_GAP;
          ctl_d.gap   = '0;
        end else if (tick) begin
          ctl_d.dur = sat_inc(ctl_q.dur);
        end
      end
      ST_GAP: begin
        if (tick) begin
          ctl_d.gap = gap_inc;
          if (gap_inc == LETTER_T && ctl_q.len != '0) begin
            letter_valid_d = 1'b1;
            letter_bits_d  = ctl_q.elems;
            letter_len_d   = ctl_q.len;
            ctl_d.elems    = '0;
            ctl_d.len      = '0;
          end
          if (gap_inc == WORD_T) begin
            word_gap_d  = 1'b1;
            ctl_d.state = ST_IDLE;
          end
        end
        // A press overrides the gap; a letter closing this cycle is still emitted.
        if (press) begin
          ctl_d.state = ST_PRESS;
          ctl_d.dur   = '0;
        end
      end
      default: ctl_d = CTL_RESET;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      ctl_q        <= CTL_RESET;
      key_q        <= 1'b0;
      sym_valid    <= 1'b0;
      sym          <= 1'b0;
      letter_valid <= 1'b0;
      letter_bits  <= '0;
      letter_len   <= '0;
      word_gap     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      ctl_q        <= ctl_d;
      key_q        <= key_clean;
      sym_valid    <= sym_valid_d;
      sym          <= sym_d;
      letter_valid <= letter_valid_d;
      letter_bits  <= letter_bits_d;
      letter_len   <= letter_len_d;
      word_gap     <= word_gap_d;
      overflow     <= overflow_d;
    end
  end

endmodule
